// File: rtl/grid_scan.sv
// Raster front end: tracks board cell under the beam, fetches its kind and tile colour.
// Optional build macro GRID_LINE_EN draws white lines on tile row/column 0.
module grid_scan #(
    parameter int unsigned BOARD_X0   = 80,
    parameter int unsigned BOARD_Y0   = 40,
    parameter int unsigned COLS       = 10,
    parameter int unsigned ROWS       = 6,
    parameter int unsigned TILE_W     = 48,
    parameter int unsigned TILE_H     = 70,
    parameter logic [11:0] BG_CLR     = 12'h000,
    parameter logic [4:0]  KIND_EMPTY = 5'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  px,
    input  logic [9:0]  py,
    input  logic        de_in,
    input  logic        hs_in,
    input  logic        vs_in,
    output logic [6:0]  map_addr,
    input  logic [4:0]  map_kind,
    output logic [4:0]  kind,
    output logic [5:0]  tx,
    output logic [6:0]  ty,
    input  logic [11:0] clr_in,
    output logic [11:0] rgb,
    output logic        de_out,
    output logic        hs_out,
    output logic        vs_out
);

    localparam int unsigned COL_W = (COLS   > 1) ? $clog2(COLS)   : 1;
    localparam int unsigned ROW_W = (ROWS   > 1) ? $clog2(ROWS)   : 1;
    localparam int unsigned XW    = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int unsigned YW    = (TILE_H > 1) ? $clog2(TILE_H) : 1;

    localparam logic [9:0]    X0    = 10'(BOARD_X0);
    localparam logic [9:0]    X1    = 10'(BOARD_X0 + COLS * TILE_W);
    localparam logic [9:0]    Y0    = 10'(BOARD_Y0);
    localparam logic [9:0]    Y1    = 10'(BOARD_Y0 + ROWS * TILE_H);
    localparam logic [XW-1:0] XLAST = XW'(TILE_W - 1);
    localparam logic [YW-1:0] YLAST = YW'(TILE_H - 1);

    // running position counters; the registered values double as stage-1 state
    logic [COL_W-1:0] col, col_n;
    logic [ROW_W-1:0] row, row_n;
    logic [XW-1:0]    xoff, xoff_n;
    logic [YW-1:0]    yoff, yoff_n;
    logic             in_x, in_y, in_reg;
    logic [6:0]       addr_n;
    logic             s1_in;

    logic             s2_in;

    logic             s3_in;
    logic             s3_empty;
    logic [11:0]      s3_clr;
`ifdef GRID_LINE_EN
    logic             s3_grid;
`endif

    logic [3:0]       de_sr, hs_sr, vs_sr;
    logic [11:0]      rgb_n;

    always_comb begin
        in_x   = (px >= X0) && (px < X1);
        in_y   = (py >= Y0) && (py < Y1);
        in_reg = de_in && in_x && in_y;

        col_n  = col;
        xoff_n = xoff;
        if (de_in && (px == X0)) begin
            col_n  = '0;
            xoff_n = '0;
        end else if (in_reg) begin
            if (xoff == XLAST) begin
                xoff_n = '0;
                col_n  = col + COL_W'(1);
            end else begin
                xoff_n = xoff + XW'(1);
            end
        end

        // vertical step once per line at the start of active video
        row_n  = row;
        yoff_n = yoff;
        if (de_in && (px == '0)) begin
            if (py == Y0) begin
                row_n  = '0;
                yoff_n = '0;
            end else if (in_y) begin
                if (yoff == YLAST) begin
                    yoff_n = '0;
                    row_n  = row + ROW_W'(1);
                end else begin
                    yoff_n = yoff + YW'(1);
                end
            end
        end

        addr_n = in_reg ? 7'(32'(row_n) * COLS + 32'(col_n)) : '0;
    end

    // S1: counters, region flag, map address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col      <= '0;
            row      <= '0;
            xoff     <= '0;
            yoff     <= '0;
            s1_in    <= 1'b0;
            map_addr <= '0;
        end else begin
            col      <= col_n;
            row      <= row_n;
            xoff     <= xoff_n;
            yoff     <= yoff_n;
            s1_in    <= in_reg;
            map_addr <= addr_n;
        end
    end

    // S2: map data arrives, present kind and in-tile position to the tile ROM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_in <= 1'b0;
            kind  <= '0;
            tx    <= '0;
            ty    <= '0;
        end else begin
            s2_in <= s1_in;
            kind  <= s1_in ? map_kind : KIND_EMPTY;
            tx    <= 6'(xoff);
            ty    <= 7'(yoff);
        end
    end

    // S3: tile colour arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_in    <= 1'b0;
            s3_empty <= 1'b0;
            s3_clr   <= '0;
`ifdef GRID_LINE_EN
            s3_grid  <= 1'b0;
`endif
        end else begin
            s3_in    <= s2_in;
            s3_empty <= (kind == KIND_EMPTY);
            s3_clr   <= clr_in;
`ifdef GRID_LINE_EN
            s3_grid  <= (tx == '0) || (ty == '0);
`endif
        end
    end

    // S4: de_sr[2] is the blanking flag of the pixel currently in S3
    always_comb begin
        rgb_n = BG_CLR;
        if (de_sr[2] && s3_in) begin
`ifdef GRID_LINE_EN
            if (s3_grid)
                rgb_n = 12'hFFF;
            else if (!s3_empty)
                rgb_n = s3_clr;
`else
            if (!s3_empty)
                rgb_n = s3_clr;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb   <= BG_CLR;
            de_sr <= '0;
            hs_sr <= '0;
            vs_sr <= '0;
        end else begin
            rgb   <= rgb_n;
            de_sr <= {de_sr[2:0], de_in};
            hs_sr <= {hs_sr[2:0], hs_in};
            vs_sr <= {vs_sr[2:0], vs_in};
        end
    end

    assign de_out = de_sr[3];
    assign hs_out = hs_sr[3];
    assign vs_out = vs_sr[3];

endmodule

// File: tb/tb_grid_scan.sv
// Directed bench for grid_scan: drives compressed raster lines and checks
// addresses, tile coordinates, colours and sync alignment at hand-computed points.
module tb_grid_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  px, py;
    logic        de_in, hs_in, vs_in;
    logic [6:0]  map_addr;
    logic [4:0]  map_kind;
    logic [4:0]  kind;
    logic [5:0]  tx;
    logic [6:0]  ty;
    logic [11:0] clr_in;
    logic [11:0] rgb;
    logic        de_out, hs_out, vs_out;

    logic [4:0]  mem [0:127];

`ifdef GRID_LINE_EN
    localparam bit GRID = 1'b1;
`else
    localparam bit GRID = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // map data follows the registered address, i.e. one cycle after the pixel
    assign map_kind = mem[map_addr];

    always #5 clk = ~clk;

    grid_scan dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .px       (px),
        .py       (py),
        .de_in    (de_in),
        .hs_in    (hs_in),
        .vs_in    (vs_in),
        .map_addr (map_addr),
        .map_kind (map_kind),
        .kind     (kind),
        .tx       (tx),
        .ty       (ty),
        .clr_in   (clr_in),
        .rgb      (rgb),
        .de_out   (de_out),
        .hs_out   (hs_out),
        .vs_out   (vs_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pix(input int x, input int y, input logic de = 1'b1, input logic hs = 1'b1);
        px    = 10'(x);
        py    = 10'(y);
        de_in = de;
        hs_in = hs;
        vs_in = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int x0, input int x1, input int y);
        for (int x = x0; x <= x1; x++) pix(x, y);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 5'd0;
        mem[0]  = 5'd3;
        mem[1]  = 5'd2;
        mem[12] = 5'd7;
        mem[50] = 5'd4;
        mem[59] = 5'd9;

        rst_n  = 1'b0;
        px     = 10'd300;
        py     = 10'd100;
        de_in  = 1'b1;
        hs_in  = 1'b1;
        vs_in  = 1'b1;
        clr_in = 12'h000;
        #12;
        chk("rst_rgb",      rgb,      12'h000);
        chk("rst_de_out",   de_out,   1'b0);
        chk("rst_map_addr", map_addr, 7'd0);
        chk("rst_kind",     kind,     5'd0);
        chk("rst_tx",       tx,       6'd0);
        chk("rst_ty",       ty,       7'd0);
        chk("rst_hs_out",   hs_out,   1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // first valid pixel reaches the output after exactly four cycles
        pix(10, 5, 1'b1);
        chk("lat_de_c1", de_out, 1'b0);
        pix(11, 5, 1'b0);
        chk("lat_de_c2", de_out, 1'b0);
        pix(12, 5, 1'b0);
        chk("lat_de_c3", de_out, 1'b0);
        pix(13, 5, 1'b0);
        chk("lat_de_c4", de_out, 1'b1);
        chk("lat_rgb_bg", rgb, 12'h000);
        pix(14, 5, 1'b0);
        chk("lat_de_c5", de_out, 1'b0);

        for (int y = 0; y < 40; y++) pix(0, y);

        // first board pixel
        pix(0, 40);
        clr_in = 12'hABC;
        pix(80, 40);
        chk("addr_80_40", map_addr, 7'd0);
        pix(81, 40);
        chk("kind_80_40", kind, 5'd3);
        chk("tx_80_40",   tx,   6'd0);
        chk("ty_80_40",   ty,   7'd0);
        pix(82, 40);
        pix(83, 40);
        chk("rgb_80_40",  rgb,    GRID ? 12'hFFF : 12'hABC);
        chk("de_80_40",   de_out, 1'b1);

        for (int y = 41; y < 60; y++) pix(0, y);

        // tile boundary at col 1, row 0 (grid line when enabled)
        pix(0, 60);
        clr_in = 12'h5A5;
        run(80, 127, 60);
        pix(128, 60);
        chk("addr_128_60", map_addr, 7'd1);
        pix(129, 60);
        chk("kind_128_60", kind, 5'd2);
        chk("tx_128_60",   tx,   6'd0);
        chk("ty_128_60",   ty,   7'd20);
        pix(130, 60);
        pix(131, 60);
        chk("rgb_128_60",  rgb, GRID ? 12'hFFF : 12'h5A5);
        pix(132, 60);
        chk("rgb_129_60",  rgb, 12'h5A5);

        // single-cycle hsync pulse
        pix(0, 61);
        pix(600, 61, 1'b1, 1'b0);
        chk("hs_c1", hs_out, 1'b1);
        pix(601, 61);
        chk("hs_c2", hs_out, 1'b1);
        pix(602, 61);
        chk("hs_c3", hs_out, 1'b1);
        pix(603, 61);
        chk("hs_c4", hs_out, 1'b0);
        pix(604, 61);
        chk("hs_c5", hs_out, 1'b1);

        for (int y = 62; y < 119; y++) pix(0, y);

        // row 1: col 2 occupied, col 3 empty
        pix(0, 119);
        clr_in = 12'h123;
        run(80, 180, 119);
        pix(181, 119);
        chk("addr_181_119", map_addr, 7'd12);
        pix(182, 119);
        chk("kind_181_119", kind, 5'd7);
        chk("tx_181_119",   tx,   6'd5);
        chk("ty_181_119",   ty,   7'd9);
        pix(183, 119);
        pix(184, 119);
        chk("rgb_181_119",  rgb,  12'h123);
        run(185, 233, 119);
        pix(234, 119);
        chk("addr_234_119", map_addr, 7'd13);
        pix(235, 119);
        chk("kind_234_119", kind, 5'd0);
        pix(236, 119);
        pix(237, 119);
        chk("rgb_empty",    rgb,  12'h000);

        for (int y = 120; y < 459; y++) pix(0, y);

        // last board pixel and the exclusive right edge
        pix(0, 459);
        clr_in = 12'hFFF;
        run(80, 558, 459);
        pix(559, 459);
        chk("addr_559_459", map_addr, 7'd59);
        pix(560, 459);
        chk("kind_559_459", kind, 5'd9);
        chk("tx_559_459",   tx,   6'd47);
        chk("ty_559_459",   ty,   7'd69);
        chk("addr_560_459", map_addr, 7'd0);
        pix(561, 459);
        pix(562, 459);
        chk("rgb_559_459",  rgb,  12'hFFF);
        pix(563, 459);
        chk("rgb_560_459",  rgb,  12'h000);
        chk("de_560_459",   de_out, 1'b1);

        // blanked pixel over board coordinates
        pix(300, 300, 1'b0);
        pix(301, 300, 1'b0);
        pix(302, 300, 1'b0);
        pix(303, 300, 1'b0);
        chk("blank_rgb", rgb,    12'h000);
        chk("blank_de",  de_out, 1'b0);

        // refill the pipeline, then reset between clock edges
        pix(80, 459);
        pix(81, 459);
        pix(82, 459);
        pix(83, 459);
        chk("pre_rst_addr", map_addr, 7'd50);
        chk("pre_rst_rgb",  rgb,      12'hFFF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rgb",  rgb,      12'h000);
        chk("arst_de",   de_out,   1'b0);
        chk("arst_addr", map_addr, 7'd0);
        chk("arst_kind", kind,     5'd0);
        chk("arst_tx",   tx,       6'd0);
        chk("arst_ty",   ty,       7'd0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
